// File: rtl/mult_pipe.sv
// mult_pipe: three-stage pipelined split-product multiplier with an optional
// running accumulator. Operands are WIDTH bits (even, >= 4). The result and
// accumulator are ACC_W bits (>= 2*WIDTH). Signed or unsigned is chosen per beat.
// A single global stall (adv) moves every stage together. Bubbles are kept, not
// compressed.
module mult_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [1:0]       acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] MODE_START = 2'd1;
  localparam logic [1:0] MODE_CONT  = 2'd2;

  // Unsigned magnitude of an operand. The most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // Apply the product sign to the magnitude, then widen to ACC_W bits.
  // Signed products are sign-extended and unsigned products are zero-extended.
  function automatic logic signed [ACC_W-1:0] extend(input logic [PW-1:0] mag,
                                                     input logic neg,
                                                     input logic sgn);
    logic [PW-1:0]    p;
    logic [ACC_W-1:0] r;
    p = neg ? (~mag + 1'b1) : mag;
    r = '0;
    r[PW-1:0] = p;
    for (int i = PW; i < ACC_W; i++) r[i] = sgn & p[PW-1];
    return signed'(r);
  endfunction

  logic adv;

  logic             vld_p0, vld_p1, vld_p2;
  logic [WIDTH-1:0] mag_a_p0, mag_b_p0;
  logic             neg_p0, sgn_p0;
  logic [1:0]       mode_p0;

  logic [WIDTH-1:0] pp_ll_p1, pp_hl_p1, pp_lh_p1, pp_hh_p1;
  logic             neg_p1, sgn_p1;
  logic [1:0]       mode_p1;

  logic signed [ACC_W-1:0] acc_p2, result_p2;

  logic [PW-1:0]           mag_prod;
  logic signed [ACC_W-1:0] ext_prod;
  logic signed [ACC_W-1:0] acc_sum;

  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;
  assign result    = unsigned'(result_p2);

  // ---- stage boundary: inputs -> p0 (magnitudes and product sign) ----
  // Capture the operand magnitudes, the product sign and the mode of each accepted slot.
  always_ff @(posedge clk) begin
    if (adv) begin
      mag_a_p0 <= magnitude(a, is_signed);
      mag_b_p0 <= magnitude(b, is_signed);
      neg_p0   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      sgn_p0   <= is_signed;
      mode_p0  <= acc_mode;
    end
  end

  // ---- stage boundary: p0 -> p1 (half-width partial products) ----
  // Register the four half-width partial products and carry the sign and mode bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      pp_ll_p1 <= WIDTH'(mag_a_p0[H-1:0])     * WIDTH'(mag_b_p0[H-1:0]);
      pp_hl_p1 <= WIDTH'(mag_a_p0[WIDTH-1:H]) * WIDTH'(mag_b_p0[H-1:0]);
      pp_lh_p1 <= WIDTH'(mag_a_p0[H-1:0])     * WIDTH'(mag_b_p0[WIDTH-1:H]);
      pp_hh_p1 <= WIDTH'(mag_a_p0[WIDTH-1:H]) * WIDTH'(mag_b_p0[WIDTH-1:H]);
      neg_p1   <= neg_p0;
      sgn_p1   <= sgn_p0;
      mode_p1  <= mode_p0;
    end
  end

  // ---- stage boundary: p1 -> p2 (combine, sign, accumulate) ----
  // hh and ll do not overlap, so concatenating them stands in for their sum.
  assign mag_prod = {pp_hh_p1, pp_ll_p1}
                  + (PW'(pp_hl_p1) << H)
                  + (PW'(pp_lh_p1) << H);
  assign ext_prod = extend(mag_prod, neg_p1, sgn_p1);
  assign acc_sum  = acc_p2 + ext_prod;

  // Advance the valid bits. Update acc and result only when a valid beat enters p2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      acc_p2    <= '0;
      result_p2 <= '0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        case (mode_p1)
          MODE_START: begin
            acc_p2    <= ext_prod;
            result_p2 <= ext_prod;
          end
          MODE_CONT: begin
            acc_p2    <= acc_sum;
            result_p2 <= acc_sum;
          end
          default: result_p2 <= ext_prod;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed testbench for mult_pipe.
// Instance dut uses ACC_W=40 and instance dut32 uses ACC_W=32; both share one
// stimulus stream.
module tb_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        is_signed;
  logic [1:0]  acc_mode;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [39:0] result;
  logic        in_ready32, out_valid32;
  logic [31:0] result32;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mult_pipe #(.WIDTH(16), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .acc_mode(acc_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  mult_pipe #(.WIDTH(16), .ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a), .b(b), .is_signed(is_signed), .acc_mode(acc_mode),
    .out_valid(out_valid32), .out_ready(out_ready), .result(result32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one beat, wait for its result, and check both instances.
  task automatic run_beat(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic ts, input logic [1:0] tm,
                          input logic [39:0] exp40, input logic [31:0] exp32);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; is_signed = ts; acc_mode = tm;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_r40"}, 64'(result), 64'(exp40));
    chk({tag, "_vld32"}, 64'(out_valid32), 64'd1);
    chk({tag, "_r32"}, 64'(result32), 64'(exp32));
  endtask

  initial begin
    int k, got_n, cyc;
    logic        stall;
    logic [39:0] held;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    is_signed = 1'b0; acc_mode = 2'd0; out_ready = 1'b1;

    // Check the reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Unsigned 0xFFFF*0xFFFF: out_valid rises after the third edge.
    @(negedge clk);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; is_signed = 1'b0; acc_mode = 2'd0;
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); in_valid = 1'b0;
    chk("lat_e1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_e2", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_e3", 64'(out_valid), 64'd1);
    chk("ffff_sq", 64'(result), 64'h00FFFE0001);
    @(negedge clk);
    chk("lat_bubble", 64'(out_valid), 64'd0);

    // Signed extremes.
    run_beat("s_min_min", 16'h8000, 16'h8000, 1'b1, 2'd0, 40'h0040000000, 32'h40000000);
    run_beat("s_min_one", 16'h8000, 16'h0001, 1'b1, 2'd0, 40'hFFFFFF8000, 32'hFFFF8000);
    run_beat("s_max_m1", 16'h7FFF, 16'hFFFF, 1'b1, 2'd0, 40'hFFFFFF8001, 32'hFFFF8001);

    // Backpressure: stream k*k for k=1..6 and stall during cycles 4 and 5.
    k = 1; got_n = 0; held = '0;
    for (cyc = 0; cyc < 30 && got_n < 6; cyc++) begin
      @(negedge clk);
      stall     = (cyc == 4 || cyc == 5);
      out_ready = !stall;
      in_valid  = (k <= 6);
      a = 16'(k); b = 16'(k); is_signed = 1'b0; acc_mode = 2'd0;
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'(!stall));
      chk("bp_in_ready32", 64'(in_ready32), 64'(!stall));
      if (cyc == 5) begin
        chk("bp_hold_vld", 64'(out_valid), 64'd1);
        chk("bp_hold_res", 64'(result), 64'(held));
      end
      held = result;
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        got_n++;
        chk("bp_res", 64'(result), 64'(got_n * got_n));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 64'(got_n), 64'd6);

    // Signed accumulate: 100*200 = 20000, then +3*(-5) = 19985,
    // a plain 7*7 = 49 that leaves acc alone, then +2*2 = 19989.
    run_beat("acc_start", 16'd100, 16'd200, 1'b1, 2'd1, 40'd20000, 32'd20000);
    run_beat("acc_cont",  16'd3, 16'hFFFB, 1'b1, 2'd2, 40'd19985, 32'd19985);
    run_beat("acc_plain", 16'd7, 16'd7, 1'b1, 2'd0, 40'd49, 32'd49);
    run_beat("acc_cont2", 16'd2, 16'd2, 1'b1, 2'd2, 40'd19989, 32'd19989);

    // Unsigned wrap: the 32-bit instance wraps, while the 40-bit one carries.
    run_beat("wrap_start", 16'hFFFF, 16'hFFFF, 1'b0, 2'd1, 40'h00FFFE0001, 32'hFFFE0001);
    run_beat("wrap_cont",  16'hFFFF, 16'hFFFF, 1'b0, 2'd2, 40'h01FFFC0002, 32'hFFFC0002);

    // Reset with three continue beats of 5*5 in flight.
    @(negedge clk);
    in_valid = 1'b1; a = 16'd5; b = 16'd5; is_signed = 1'b0; acc_mode = 2'd2;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_result32", 64'(result32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_stale", 64'(out_valid), 64'd0);
    end
    run_beat("arst_cont", 16'd1, 16'd1, 1'b0, 2'd2, 40'd1, 32'd1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
